// File: rtl/bht_upd_arb.sv
// rtl/bht_upd_arb.sv - BHT port scheduler: fetch lookups vs. queued resolve-stage history updates
// Optional macro BHT_FWD_EN: forward pending update bits for lk_addr into lk_hist.
module bht_upd_arb #(
  parameter int AW         = 10,
  parameter int HW         = 10,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lk_valid,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_ready,
  output logic [HW-1:0] lk_hist,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_addr,
  input  logic          upd_taken,
  output logic          upd_ready,
  output logic          bht_wr_en,
  output logic          bht_wr_data,
  output logic [AW-1:0] bht_addr,
  input  logic [HW-1:0] bht_rd_data,
  output logic [CW-1:0] fifo_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  q_addr [DEPTH];
  logic [DEPTH-1:0] q_taken;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [SW-1:0]  stall_cnt, stall_nxt;
  logic           enq, deq;

  // Backpressure comes from the registered count only, never from a same-cycle drain.
  assign upd_ready   = (cnt < CW'(DEPTH));
  assign enq         = upd_valid && upd_ready;
  assign fifo_cnt    = cnt;
  assign bht_wr_en   = deq && reset;
  assign bht_wr_data = q_taken[rd_ptr];

  always_comb begin
    state_nxt = state;
    stall_nxt = stall_cnt;
    deq       = 1'b0;
    lk_ready  = 1'b1;
    case (state)
      IDLE: stall_nxt = '0;
      PEND: begin
        if (lk_valid) stall_nxt = stall_cnt + SW'(1);
        else begin
          deq       = 1'b1;
          stall_nxt = '0;
        end
      end
      FORCE: begin
        lk_ready  = 1'b0;
        deq       = 1'b1;
        stall_nxt = '0;
      end
      default: stall_nxt = '0;
    endcase

    cnt_nxt  = cnt + CW'(enq) - CW'(deq);
    bht_addr = deq ? q_addr[rd_ptr] : lk_addr;

    case (state)
      IDLE:  if (cnt_nxt != '0) state_nxt = PEND;
      PEND: begin
        if (lk_valid && (stall_nxt == SW'(STARVE_MAX))) state_nxt = FORCE;
        else if (cnt_nxt == '0)                         state_nxt = IDLE;
      end
      FORCE: state_nxt = (cnt_nxt != '0) ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stall_cnt <= stall_nxt;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      q_addr[wr_ptr]  <= upd_addr;
      q_taken[wr_ptr] <= upd_taken;
    end
  end

`ifdef BHT_FWD_EN
  logic [HW-1:0] fwd_hist;
  logic [PW-1:0] fwd_idx;

  // Replay every live entry for this index, oldest first, in the BHT shift direction.
  always_comb begin
    fwd_hist = bht_rd_data;
    fwd_idx  = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < cnt) && (q_addr[fwd_idx] == lk_addr))
        fwd_hist = {fwd_hist[HW-2:0], q_taken[fwd_idx]};
    end
  end

  assign lk_hist = fwd_hist;
`else
  assign lk_hist = bht_rd_data;
`endif

endmodule

// File: tb/tb_bht_upd_arb.sv
// tb/tb_bht_upd_arb.sv - scoreboard bench for bht_upd_arb
module tb_bht_upd_arb;
  localparam int AW = 10;
  localparam int HW = 10;
`ifdef BHT_FWD_EN
  localparam logic [HW-1:0] FWD_EXP = 10'b0000000011;
`else
  localparam logic [HW-1:0] FWD_EXP = 10'b0000000000;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          lk_valid = 1'b0;
  logic [AW-1:0] lk_addr = '0;
  logic          lk_ready;
  logic [HW-1:0] lk_hist;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic          upd_taken = 1'b0;
  logic          upd_ready;
  logic          bht_wr_en;
  logic          bht_wr_data;
  logic [AW-1:0] bht_addr;
  logic [HW-1:0] bht_rd_data;
  logic [2:0]    fifo_cnt;
  logic          lk_chk = 1'b0;

  int total = 0;
  int bad = 0;
  wr_t wq[$];
  logic [HW-1:0] hq[$];
  wr_t e;
  logic [HW-1:0] he;

  logic [HW-1:0] bmem [0:1023] = '{default: '0};

  bht_upd_arb dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready), .lk_hist(lk_hist),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .bht_wr_en(bht_wr_en), .bht_wr_data(bht_wr_data), .bht_addr(bht_addr),
    .bht_rd_data(bht_rd_data), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  assign bht_rd_data = bmem[bht_addr];
  always @(posedge clk)
    if (bht_wr_en) bmem[bht_addr] <= {bmem[bht_addr][HW-2:0], bht_wr_data};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic t);
    wq.push_back({a, t});
  endtask

  // Offer one update; it is queued on the scoreboard only after the accepting edge.
  task automatic enq(input logic [AW-1:0] a, input logic t);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_taken = t;
    @(negedge clk);
    chk("enq_upd_ready", 32'(upd_ready), 1);
    step();
    push_wr(a, t);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fifo_cnt != 3'd0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_done", 32'(fifo_cnt), 0);
  endtask

  always @(negedge clk) begin
    if (reset && bht_wr_en) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got write addr=%0d data=%0b expected none", bht_addr, bht_wr_data);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bht_addr), 32'(e.addr));
        chk("wr_data", 32'(bht_wr_data), 32'(e.d));
      end
    end
    if (reset && lk_chk && lk_valid) begin
      chk("lk_ready_on_lookup", 32'(lk_ready), 1);
      if (hq.size() != 0) begin
        he = hq.pop_front();
        chk("lk_hist", 32'(lk_hist), 32'(he));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // reset
    lk_addr = 10'd9;
    step();
    step();
    chk("rst_wr_en_in_reset", 32'(bht_wr_en), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("rst_lk_ready", 32'(lk_ready), 1);
    chk("rst_upd_ready", 32'(upd_ready), 1);
    chk("rst_wr_en", 32'(bht_wr_en), 0);
    chk("rst_bht_addr", 32'(bht_addr), 32'(lk_addr));
    step();

    // drain in order with no lookups, then read back the shifted history
    enq(10'd3, 1'b1);
    enq(10'd3, 1'b0);
    enq(10'd3, 1'b1);
    step();
    chk("t2_cnt_idle", 32'(fifo_cnt), 0);
    lk_valid = 1'b1;
    lk_addr  = 10'd3;
    lk_chk   = 1'b1;
    hq.push_back(10'b0000000101);
    step();
    lk_chk = 1'b0;

    // fill under held lookups, block the fifth, see exactly one forced drain
    lk_addr = 10'd7;
    enq(10'd10, 1'b1);
    enq(10'd11, 1'b0);
    enq(10'd12, 1'b1);
    enq(10'd13, 1'b1);
    upd_valid = 1'b1;
    upd_addr  = 10'd14;
    upd_taken = 1'b0;
    @(negedge clk);
    chk("t3_full_upd_ready", 32'(upd_ready), 0);
    chk("t3_full_cnt", 32'(fifo_cnt), 4);
    chk("t3_pre_force_lk_ready", 32'(lk_ready), 1);
    @(negedge clk);
    chk("t3_force_lk_ready", 32'(lk_ready), 0);
    chk("t3_force_cnt", 32'(fifo_cnt), 4);
    chk("t3_force_upd_ready", 32'(upd_ready), 0);
    upd_valid = 1'b0;
    @(negedge clk);
    chk("t3_post_force_lk_ready", 32'(lk_ready), 1);
    chk("t3_post_force_cnt", 32'(fifo_cnt), 3);
    chk("t3_post_force_upd_ready", 32'(upd_ready), 1);
    step();
    lk_valid = 1'b0;
    wait_idle();

    // simultaneous enqueue and drain at cnt=2
    lk_valid = 1'b1;
    lk_addr  = 10'd0;
    enq(10'd20, 1'b1);
    enq(10'd21, 1'b0);
    lk_valid  = 1'b0;
    upd_valid = 1'b1;
    upd_addr  = 10'd22;
    upd_taken = 1'b1;
    @(negedge clk);
    chk("t4_cnt_before", 32'(fifo_cnt), 2);
    chk("t4_wr_en", 32'(bht_wr_en), 1);
    chk("t4_upd_ready", 32'(upd_ready), 1);
    step();
    push_wr(10'd22, 1'b1);
    upd_valid = 1'b0;
    @(negedge clk);
    chk("t4_cnt_after", 32'(fifo_cnt), 2);
    wait_idle();

    // reset with three pending updates discards them
    lk_valid = 1'b1;
    lk_addr  = 10'd0;
    enq(10'd30, 1'b1);
    enq(10'd31, 1'b1);
    enq(10'd32, 1'b1);
    @(negedge clk);
    chk("t5_pre_rst_cnt", 32'(fifo_cnt), 3);
    reset    = 1'b0;
    lk_valid = 1'b0;
    wq.delete();
    #1;
    chk("t5_wr_en_in_reset", 32'(bht_wr_en), 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_cnt_after_rst", 32'(fifo_cnt), 0);
    chk("t5_wr_en_after_rst", 32'(bht_wr_en), 0);
    chk("t5_upd_ready_after_rst", 32'(upd_ready), 1);
    chk("t5_lk_ready_after_rst", 32'(lk_ready), 1);
    step();
    lk_valid = 1'b1;
    lk_addr  = 10'd30;
    lk_chk   = 1'b1;
    hq.push_back(10'b0000000000);
    step();
    lk_addr = 10'd3;
    hq.push_back(10'b0000000101);
    step();
    lk_chk   = 1'b0;

    // lookup to an index with pending updates
    lk_addr = 10'd5;
    enq(10'd5, 1'b1);
    enq(10'd5, 1'b1);
    lk_chk = 1'b1;
    hq.push_back(FWD_EXP);
    step();
    lk_chk   = 1'b0;
    lk_valid = 1'b0;
    wait_idle();
    lk_valid = 1'b1;
    lk_chk   = 1'b1;
    hq.push_back(10'b0000000011);
    step();
    lk_chk   = 1'b0;
    lk_valid = 1'b0;
    step();

    chk("sb_wr_empty", 32'(wq.size()), 0);
    chk("sb_lk_empty", 32'(hq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bht_upd_arb.md
Name: bht_upd_arb

Overview:
Port scheduler for the single-ported branch history table (BHT). It shares the BHT address port between fetch-stage lookups and resolve-stage history updates. Updates are queued in a small FIFO and drained into the BHT whenever no lookup is presented. A starvation counter forces a drain cycle so that updates are never blocked indefinitely.

Parameters:
AW, 10, BHT index width (matches 1024-entry BHT)
HW, 10, BHT history width per entry
DEPTH, 4, update FIFO depth (power of two, >=2)
STARVE_MAX, 4, consecutive blocked cycles before a forced drain

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
lk_valid  input  1  lookup request this cycle
lk_addr  input  AW  lookup index
lk_ready  output  1  lookup granted BHT port this cycle
lk_hist  output  HW  history for lk_addr, valid when lk_valid&&lk_ready
upd_valid  input  1  resolved-branch update offered
upd_addr  input  AW  index to update
upd_taken  input  1  resolved outcome (1 = taken)
upd_ready  output  1  FIFO can accept update
bht_wr_en  output  1  to BHT wr_en
bht_wr_data  output  1  to BHT wr_data (shifted into entry)
bht_addr  output  AW  to BHT addr
bht_rd_data  input  HW  from BHT rd_data (combinational read)
fifo_cnt  output  log2(DEPTH)+1  entries pending

Behaviour:
- While reset=0 at a clock edge: FIFO emptied (cnt=0, pointers 0), stall_cnt=0, state=IDLE. While reset=0, bht_wr_en is forced 0 combinationally. After reset: lk_ready=1, upd_ready=1, fifo_cnt=0, bht_addr=lk_addr.
- Update enqueue: accepted on an edge with upd_valid&&upd_ready. upd_ready = (cnt<DEPTH), from registered count only, with no dependence on same-cycle dequeue. Simultaneous enqueue+dequeue leaves cnt unchanged.
- Minimum update latency: enqueued at edge N, BHT write no earlier than cycle N+1. There is no bypass path into the BHT.
- States:
  - IDLE: FIFO empty. lk_ready=1, bht_wr_en=0. Goes to PEND when cnt becomes nonzero.
  - PEND: FIFO nonempty.
    - If lk_valid: lookup wins. lk_ready=1, bht_addr=lk_addr, bht_wr_en=0, stall_cnt increments.
    - Else: drain. bht_wr_en=1, bht_addr=head.addr, bht_wr_data=head.taken, dequeue at edge, stall_cnt=0.
    - Goes to FORCE when stall_cnt reaches STARVE_MAX (i.e. after STARVE_MAX consecutive blocked cycles). Goes to IDLE when the last entry drains and no enqueue occurs.
  - FORCE: one cycle only. lk_ready=0, drain head unconditionally, stall_cnt=0. Next state is PEND if cnt after the edge is nonzero, else IDLE.
- Lookup-read path: lk_hist = bht_rd_data, combinational, in the same cycle. It is meaningful only when lk_ready=1.
- A lookup with lk_ready=0 is not consumed; the requester holds it. A lookup to the same index as a pending update returns pre-update history, unless BHT_FWD_EN is defined.
- Updates write in FIFO order. Multiple updates to the same index apply in arrival order.
- Counter widths: cnt saturates logically at DEPTH (it cannot exceed DEPTH because of upd_ready). Pointers wrap modulo DEPTH. stall_cnt width is clog2(STARVE_MAX+1).
- Reset mid-operation: pending updates are discarded, and no write is issued during the reset cycle.

Optional Feature:
Macro BHT_FWD_EN.
- Defined: lk_hist = bht_rd_data with the taken bits of every pending FIFO entry whose addr==lk_addr shifted in, oldest first, using the BHT shift direction (new bit into LSB, MSB dropped). This is combinational over all DEPTH entries.
- Not defined: lk_hist = bht_rd_data, unmodified.

Test Plan:
1. Reset with reset=0 for 2 cycles, then 1 -> fifo_cnt=0, lk_ready=1, upd_ready=1, bht_wr_en=0.
2. lk_valid=0. Enqueue (addr=3,taken=1),(3,0),(3,1) on consecutive cycles -> bht_wr_en pulses at cycles 1,2,3 after each enqueue with data 1,0,1 at addr 3. Lookup of addr 3 then returns lk_hist=10'b0000000101.
3. Fill 4 updates with lk_valid=1 held -> upd_ready=0 at cnt=4. 5th upd_valid is not accepted. A FORCE cycle occurs after 4 blocked cycles (lk_ready=0 for exactly one cycle, cnt 4->3, upd_ready=1 the next cycle).
4. Simultaneous enqueue and drain at cnt=2 -> cnt stays 2, and order is preserved at the BHT write port.
5. Assert reset=0 with cnt=3 -> the next cycle cnt=0, no bht_wr_en during or after reset, and subsequent lookups see the unmodified BHT.
6. (BHT_FWD_EN) BHT entry 5 = 0. Pending (5,1),(5,1) with lookup of addr 5 -> lk_hist=10'b11. Without the macro -> lk_hist=0.
